// File: rtl/fsm_filter_n_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_filter_pkg
// Purpose  : Shared types for the fsm_filter_n debounce block. Holds the
//            per-channel state encoding used by fsm_filter_ch.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fsm_filter_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_RISING  = 2'd1,
    ST_HIGH    = 2'd2,
    ST_FALLING = 2'd3
  } state_t;

endpackage : fsm_filter_pkg
`default_nettype wire

// File: rtl/fsm_filter_n_if.sv
`default_nettype none
// ============================================================================
// Module   : fsm_filter_n_if
// Purpose  : Bundles the sample enable, raw inputs and filtered outputs of
//            fsm_filter_n.
// Ports    : en   - shared sample enable
//            a    - raw level inputs, one bit per channel
//            out  - filtered levels
//            rise - one-cycle pulse on each 0->1 of out
//            fall - one-cycle pulse on each 1->0 of out
//            master drives en/a; slave (the filter) drives out/rise/fall.
// Revision : 1.0 - initial release
// ============================================================================
interface fsm_filter_n_if #(
  parameter int CHANNELS = 4
) ();

  logic                en;
  logic [CHANNELS-1:0] a;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;

  modport master (output en, output a, input out, input rise, input fall);
  modport slave  (input en, input a, output out, output rise, output fall);

endinterface : fsm_filter_n_if
`default_nettype wire

// File: rtl/fsm_filter_n_ch.sv
`default_nettype none
// ============================================================================
// Module   : fsm_filter_ch
// Purpose  : One debounce channel. out follows a only after a has held the
//            new level for RISE_CNT (going high) or FALL_CNT (going low)
//            consecutive enabled samples; rise/fall pulse with each change.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            en   - sample enable
//            a    - raw input level
//            out  - filtered level
//            rise - one-cycle pulse coincident with out 0->1
//            fall - one-cycle pulse coincident with out 1->0
// Revision : 1.0 - initial release
// ============================================================================
module fsm_filter_ch
  import fsm_filter_pkg::*;
#(
  parameter int RISE_CNT = 3,
  parameter int FALL_CNT = 3,
  parameter int CNT_W    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  output logic out,
  output logic rise,
  output logic fall
);

  // Run length reached on the sample that completes a qualifying run.
  localparam logic [CNT_W-1:0] c_rise_last = CNT_W'(RISE_CNT - 1);
  localparam logic [CNT_W-1:0] c_fall_last = CNT_W'(FALL_CNT - 1);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      case (state_q)
        ST_LOW: begin
          cnt_d = '0;
          if (a) begin
            if (RISE_CNT == 1) begin
              state_d = ST_HIGH;
              rise_d  = 1'b1;
            end else begin
              state_d = ST_RISING;
              cnt_d   = c_one;
            end
          end
        end
        ST_RISING: begin
          if (!a) begin
            // Run broken: reject as a glitch.
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_q == c_rise_last) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + c_one;
          end
        end
        ST_HIGH: begin
          cnt_d = '0;
          if (!a) begin
            if (FALL_CNT == 1) begin
              state_d = ST_LOW;
              fall_d  = 1'b1;
            end else begin
              state_d = ST_FALLING;
              cnt_d   = c_one;
            end
          end
        end
        ST_FALLING: begin
          if (a) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == c_fall_last) begin
            state_d = ST_LOW;
            cnt_d   = '0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + c_one;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // out is a pure decode of the state register, so it changes on the same
  // edge as the registered pulses.
  assign out  = (state_q == ST_HIGH) || (state_q == ST_FALLING);
  assign rise = rise_q;
  assign fall = fall_q;

endmodule : fsm_filter_ch
`default_nettype wire

// File: rtl/fsm_filter_n.sv
`default_nettype none
// ============================================================================
// Module   : fsm_filter_n
// Purpose  : CHANNELS independent debounce filters sharing clock, reset and
//            sample enable.
// Ports    : clk - clock, rising edge
//            rst - synchronous active-high reset
//            bus - fsm_filter_n_if.slave (en, a in; out, rise, fall out)
// Revision : 1.0 - initial release
// ============================================================================
module fsm_filter_n #(
  parameter int CHANNELS = 4,
  parameter int RISE_CNT = 3,
  parameter int FALL_CNT = 3
) (
  input  logic          clk,
  input  logic          rst,
  fsm_filter_n_if.slave bus
);

  localparam int MAX_CNT = (RISE_CNT > FALL_CNT) ? RISE_CNT : FALL_CNT;
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);

  logic [CHANNELS-1:0] w_out;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    fsm_filter_ch #(
      .RISE_CNT (RISE_CNT),
      .FALL_CNT (FALL_CNT),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en),
      .a    (bus.a[g]),
      .out  (w_out[g]),
      .rise (w_rise[g]),
      .fall (w_fall[g])
    );
  end

  assign bus.out  = w_out;
  assign bus.rise = w_rise;
  assign bus.fall = w_fall;

endmodule : fsm_filter_n
`default_nettype wire

// File: doc/fsm_filter_n.md
# fsm_filter_n

Parametrised, multi-channel successor to the two-state level-follower FSM. Each channel tracks a single-bit input and drives a registered output that changes level only after the input has held the new level for a programmable number of consecutive enabled samples. This provides rise/fall hysteresis (debounce). One-cycle edge pulses accompany each output transition. The block sits between raw level inputs (buttons, comparator or status lines) and downstream control logic; all channels share one clock, one reset and one enable.

## Interface
- `CHANNELS`, default 4: number of independent channels (≥1).
- `RISE_CNT`, default 3: consecutive high samples required to drive `out` high (1..65535).
- `FALL_CNT`, default 3: consecutive low samples required to drive `out` low (1..65535).
- `CNT_W`, derived: `$clog2(max(RISE_CNT,FALL_CNT)+1)`; not user-overridden.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  sample enable, shared by all channels.
- `a`  in  CHANNELS  raw inputs, one bit per channel, synchronous to `clk`.
- `out`  out  CHANNELS  filtered levels, registered.
- `rise`  out  CHANNELS  one-cycle pulse, asserted in the same cycle the corresponding `out` bit goes 0→1.
- `fall`  out  CHANNELS  one-cycle pulse, asserted in the same cycle the corresponding `out` bit goes 1→0.

## Operation
- Each channel has a 4-state FSM: LOW, RISING, HIGH, FALLING. Each channel also has a `CNT_W`-bit run counter `cnt`.
- LOW (`out`=0), sampling `a`=1:
  - If `RISE_CNT`==1 → HIGH.
  - Otherwise → RISING with `cnt`=1.
- LOW, sampling `a`=0: stay in LOW with `cnt`=0.
- RISING, sampling `a`=1: `cnt`+1. When `cnt`+1==`RISE_CNT` → HIGH with `cnt`=0.
- RISING, sampling `a`=0: → LOW with `cnt`=0 (glitch rejected).
- HIGH and FALLING mirror LOW and RISING, with polarity inverted and `FALL_CNT` in place of `RISE_CNT`.
- Output levels: `out`=1 exactly in HIGH and FALLING. `out`=0 in LOW and RISING.
- Edge pulses: `rise` is 1 only on the cycle following entry to HIGH from LOW or RISING. `fall` likewise on entry to LOW from HIGH or FALLING. Both are otherwise 0.
- Width: `cnt` never exceeds `max(RISE_CNT,FALL_CNT)−1`, so there is no wrap-around.
- `en`=0: state, `cnt` and `out` are held. `rise` and `fall` are 0 on the next cycle. A run is neither broken nor extended by disabled cycles.
- Channels are fully independent. Simultaneous transitions on any subset of channels are legal.
- Default FSM branch (unreachable encoding): → LOW with `cnt`=0 and `out`=0. No X on outputs.

## Timing
- Reset: `rst`=1 sampled at an edge forces state=LOW, `cnt`=0, `out`=0, `rise`=0, `fall`=0 on all channels after that edge. Reset overrides `en` and `a`.
- Reset mid-count (RISING or FALLING) discards the run entirely. Reset in HIGH drops `out` to 0 without a `fall` pulse.
- Latency, `RISE_CNT`=N: if `a`=1 is sampled at N consecutive enabled edges, `out` is 1 after the N-th edge. `RISE_CNT`=1 gives a one-cycle registered follower.
- `fall` timing is symmetric, using `FALL_CNT`.
- Pulse alignment: `rise`/`fall` are asserted in the same cycle as the `out` change, for exactly one cycle.

## Structure
- Shared package `fsm_filter_pkg`: 2-bit state type and the encodings `ST_LOW`=0, `ST_RISING`=1, `ST_HIGH`=2, `ST_FALLING`=3.
- Sub-module `fsm_filter_ch`: one channel, with parameters `RISE_CNT`, `FALL_CNT` and `CNT_W`.
- The top level is a generate loop of `CHANNELS` instances with no cross-channel logic.

## Test plan
All scenarios use `CHANNELS`=4, `RISE_CNT`=3, `FALL_CNT`=2.
- Reset: `rst`=1 for 2 cycles with `a`=4'hF and `en`=1 → `out`, `rise` and `fall` are all 0. The first `out`[*]=1 appears only 3 enabled edges after `rst` falls.
- Rise: `a`[0]=1 for 3 enabled edges → `out`[0] is 0, 0, then 1. `rise`[0]=1 for one cycle, coincident with `out`[0] going high. Other channels stay 0.
- Glitch rejection: `a`[1] pattern 1,1,0,1,1,1 → `out`[1] rises only after the 6th edge. `rise`[1] pulses once.
- Fall hysteresis: from HIGH, `a`[2] pattern 0,1,0,0 → `out`[2] stays 1 through edge 3 and goes 0 after edge 4. `fall`[2] pulses once.
- Enable freeze: `a`[3]=1 for 2 enabled edges, then `en`=0 for 5 cycles, then 1 more enabled high sample → `out`[3] goes 1 after that sample. No pulses occur while `en`=0.
- Reset mid-run and parallel channels:
  - `a`=4'hF for 2 edges, then `rst` for 1 cycle, then 3 more edges → `out`=4'hF only after the 3rd post-reset edge.
  - `rise`=4'hF in a single cycle.
